// File: rtl/vsync_pkg.sv
// Shared definitions for the vertical timing stage: state encoding,
// total-frame-length helper and the parameter legality check.
package vsync_pkg;

    typedef enum logic [1:0] {
        ACTIVE      = 2'd0,
        FRONT_PORCH = 2'd1,
        SYNC        = 2'd2,
        BACK_PORCH  = 2'd3
    } vstate_e;

    // Total number of lines in one frame.
    function automatic int calc_vtotal(input int res, input int fp, input int sw, input int bp);
        return res + fp + sw + bp;
    endfunction

    // Every region needs at least one line and the frame must fit the counter.
    function automatic bit params_legal(input int bus_width, input int res, input int fp,
                                        input int sw, input int bp);
        longint limit;
        if (res < 1 || fp < 1 || sw < 1 || bp < 1) begin
            return 1'b0;
        end
        if (bus_width < 1 || bus_width > 32) begin
            return 1'b0;
        end
        limit = longint'(1) << bus_width;
        return longint'(calc_vtotal(res, fp, sw, bp)) <= limit;
    endfunction

endpackage

// File: rtl/pulse_rise_detect.sv
// Single-bit rising-edge detector. The history register resets to a
// configurable value so a level already high at reset release is not
// reported as an edge when RESET_VAL = 1.
module pulse_rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // Remember the input level of the previous clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/vsync_timing.sv
// Vertical timing stage: counts line pulses from the horizontal stage and
// steps through ACTIVE / FRONT_PORCH / SYNC / BACK_PORCH, producing vertical
// sync, frame-qualified data enable, absolute line index and a
// start-of-frame strobe.
module vsync_timing
    import vsync_pkg::*;
#(
    parameter int   busWidth     = 11,
    parameter int   resVertical  = 1080,
    parameter int   vFrontPorch  = 4,
    parameter int   vSyncWidth   = 5,
    parameter int   vBackPorch   = 36,
    parameter logic syncPolarity = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                hSyncPulse,
    input  logic                hDE,
    output logic                vSyncPulse,
    output logic                DE,
    output logic [busWidth-1:0] lineCount,
    output logic                frameStart
);

    localparam int V_TOTAL = calc_vtotal(resVertical, vFrontPorch, vSyncWidth, vBackPorch);

    // Illegal region lengths or a frame that overflows the counter stop elaboration.
    generate
        if (!params_legal(busWidth, resVertical, vFrontPorch, vSyncWidth, vBackPorch)) begin : g_bad_params
            $fatal(1, "vsync_timing: illegal timing parameters");
        end
    endgenerate

    localparam logic [busWidth-1:0] LAST_LINE = busWidth'(V_TOTAL - 1);
    localparam logic [busWidth-1:0] RES_LAST  = busWidth'(resVertical - 1);
    localparam logic [busWidth-1:0] FP_LAST   = busWidth'(vFrontPorch - 1);
    localparam logic [busWidth-1:0] SW_LAST   = busWidth'(vSyncWidth - 1);
    localparam logic [busWidth-1:0] BP_LAST   = busWidth'(vBackPorch - 1);

    vstate_e             state_q, state_d;
    logic [busWidth-1:0] region_q, region_d;
    logic [busWidth-1:0] line_q, line_d;
    logic                v_active_q, v_active_d;
    logic                vsync_q, vsync_d;
    logic                frame_start_q, frame_start_d;
    logic                line_evt;
    logic [busWidth-1:0] region_last;

    // One event per line: the history register starts high so a pulse held
    // through reset release is ignored.
    pulse_rise_detect #(
        .RESET_VAL(1'b1)
    ) u_line_rise (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (hSyncPulse),
        .rise_o(line_evt)
    );

    // Last region-relative index of the current region.
    always_comb begin
        region_last = RES_LAST;
        case (state_q)
            ACTIVE:      region_last = RES_LAST;
            FRONT_PORCH: region_last = FP_LAST;
            SYNC:        region_last = SW_LAST;
            BACK_PORCH:  region_last = BP_LAST;
            default:     region_last = RES_LAST;
        endcase
    end

    // Next-state, counters and registered-output values; everything holds
    // unless a line event arrives, except the strobe which always clears.
    always_comb begin
        state_d       = state_q;
        region_d      = region_q;
        line_d        = line_q;
        frame_start_d = 1'b0;
        if (line_evt) begin
            line_d = (line_q == LAST_LINE) ? '0 : line_q + 1'b1;
            if (region_q == region_last) begin
                region_d = '0;
                case (state_q)
                    ACTIVE:      state_d = FRONT_PORCH;
                    FRONT_PORCH: state_d = SYNC;
                    SYNC:        state_d = BACK_PORCH;
                    BACK_PORCH:  state_d = ACTIVE;
                    default:     state_d = ACTIVE;
                endcase
                frame_start_d = (state_q == BACK_PORCH);
            end else begin
                region_d = region_q + 1'b1;
            end
        end
        v_active_d = (state_d == ACTIVE);
        vsync_d    = (state_d == SYNC) ? syncPolarity : ~syncPolarity;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ACTIVE;
            region_q      <= '0;
            line_q        <= '0;
            v_active_q    <= 1'b1;
            vsync_q       <= ~syncPolarity;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            region_q      <= region_d;
            line_q        <= line_d;
            v_active_q    <= v_active_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign DE         = hDE & v_active_q;
    assign vSyncPulse = vsync_q;
    assign lineCount  = line_q;
    assign frameStart = frame_start_q;

endmodule

// File: tb/tb_vsync_timing.sv
// Bench for vsync_timing with three configurations side by side:
// 0: 4/1/2/1 active-high sync, 1: default timing active-low sync,
// 2: all regions one line long.
module tb_vsync_timing;

    typedef struct {
        int k;
        int lc;
        bit vs;
        bit fs;
        bit act;
    } exp_t;

    typedef struct {
        int hold;
        int lc;
        bit vs;
        bit fs;
        bit act;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        hs  [3];
    logic        hde [3];
    logic        vs  [3];
    logic        de  [3];
    logic        fs  [3];
    logic [10:0] lc  [3];

    int RV [3] = '{4, 1080, 1};
    int FP [3] = '{1, 4, 1};
    int SW [3] = '{2, 5, 1};
    int BP [3] = '{1, 36, 1};
    bit POL[3] = '{1'b1, 1'b0, 1'b1};
    int VT [3];
    int ml [3];

    exp_t sb[$];
    vec_t tbl[8];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vsync_timing #(.busWidth(11), .resVertical(4), .vFrontPorch(1), .vSyncWidth(2),
                   .vBackPorch(1), .syncPolarity(1'b1)) dut_a (
        .clock(clk), .reset(rst[0]), .hSyncPulse(hs[0]), .hDE(hde[0]),
        .vSyncPulse(vs[0]), .DE(de[0]), .lineCount(lc[0]), .frameStart(fs[0]));

    vsync_timing #(.busWidth(11), .resVertical(1080), .vFrontPorch(4), .vSyncWidth(5),
                   .vBackPorch(36), .syncPolarity(1'b0)) dut_b (
        .clock(clk), .reset(rst[1]), .hSyncPulse(hs[1]), .hDE(hde[1]),
        .vSyncPulse(vs[1]), .DE(de[1]), .lineCount(lc[1]), .frameStart(fs[1]));

    vsync_timing #(.busWidth(11), .resVertical(1), .vFrontPorch(1), .vSyncWidth(1),
                   .vBackPorch(1), .syncPolarity(1'b1)) dut_c (
        .clock(clk), .reset(rst[2]), .hSyncPulse(hs[2]), .hDE(hde[2]),
        .vSyncPulse(vs[2]), .DE(de[2]), .lineCount(lc[2]), .frameStart(fs[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Reference model: advance the line index and derive outputs from it.
    function automatic exp_t model_evt(input int k);
        exp_t e;
        ml[k]  = (ml[k] == VT[k] - 1) ? 0 : ml[k] + 1;
        e.k    = k;
        e.lc   = ml[k];
        e.fs   = (ml[k] == 0);
        e.act  = (ml[k] < RV[k]);
        e.vs   = (ml[k] >= RV[k] + FP[k] && ml[k] < RV[k] + FP[k] + SW[k]) ? POL[k] : !POL[k];
        return e;
    endfunction

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("lineCount[%0d] line %0d", e.k, e.lc), 32'(lc[e.k]), 32'(e.lc));
            chk($sformatf("vSyncPulse[%0d] line %0d", e.k, e.lc), 32'(vs[e.k]), 32'(e.vs));
            chk($sformatf("frameStart[%0d] line %0d", e.k, e.lc), 32'(fs[e.k]), 32'(e.fs));
        end
    endtask

    // Raise hSyncPulse for 'hold' clocks; the outputs are compared one clock
    // after the rising edge, the remaining high clocks must not count again.
    task automatic drive_pulse(input int k, input int hold, input exp_t e);
        @(negedge clk);
        hs[k] = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        compare_pop();
        for (int i = 1; i < hold; i++) @(negedge clk);
        hs[k] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   nfs;
        int   p1;
        int   p2;
        int   nlow;

        tbl[0] = '{1, 1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1, 2, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{3, 3, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1, 4, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2, 5, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1, 6, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1, 7, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1, 0, 1'b0, 1'b1, 1'b1};

        for (int k = 0; k < 3; k++) begin
            VT[k]  = RV[k] + FP[k] + SW[k] + BP[k];
            ml[k]  = 0;
            rst[k] = 1'b1;
            hs[k]  = 1'b0;
            hde[k] = 1'b1;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset lineCount[%0d]", k), 32'(lc[k]), 32'd0);
            chk($sformatf("reset vSyncPulse[%0d]", k), 32'(vs[k]), 32'(!POL[k]));
            chk($sformatf("reset frameStart[%0d]", k), 32'(fs[k]), 32'd0);
            chk($sformatf("reset DE[%0d]", k), 32'(de[k]), 32'd1);
            rst[k] = 1'b0;
        end

        // Config 0: one frame from the table, DE checked between pulses.
        for (int i = 0; i < 8; i++) begin
            e.k   = 0;
            e.lc  = tbl[i].lc;
            e.vs  = tbl[i].vs;
            e.fs  = tbl[i].fs;
            e.act = tbl[i].act;
            drive_pulse(0, tbl[i].hold, e);
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                hde[0] = j[0];
                #1;
                chk($sformatf("DE line %0d hDE %0d", tbl[i].lc, j[0]), 32'(de[0]),
                    32'(j[0] & tbl[i].act));
            end
            chk($sformatf("frameStart cleared line %0d", tbl[i].lc), 32'(fs[0]), 32'd0);
            chk($sformatf("lineCount held line %0d", tbl[i].lc), 32'(lc[0]), 32'(tbl[i].lc));
            repeat (3) @(negedge clk);
        end
        ml[0]  = tbl[7].lc;
        hde[0] = 1'b1;

        // Back-to-back pulses with one low clock count twice, then a 6-clock pulse once.
        drive_pulse(0, 1, model_evt(0));
        drive_pulse(0, 1, model_evt(0));
        drive_pulse(0, 6, model_evt(0));
        while (ml[0] != 6) drive_pulse(0, 1, model_evt(0));
        @(negedge clk);
        chk("vSyncPulse before mid-frame reset", 32'(vs[0]), 32'd1);

        // Asynchronous reset in the middle of a clock high phase while in SYNC.
        @(posedge clk);
        #2;
        rst[0] = 1'b1;
        hs[0]  = 1'b1;
        #1;
        chk("async reset lineCount", 32'(lc[0]), 32'd0);
        chk("async reset vSyncPulse", 32'(vs[0]), 32'd0);
        chk("async reset frameStart", 32'(fs[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        ml[0]  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pulse held across reset release", 32'(lc[0]), 32'd0);
        end
        hs[0] = 1'b0;
        drive_pulse(0, 1, model_evt(0));

        // Config 2: one-line regions cycle through every state on every pulse.
        for (int i = 0; i < 9; i++) drive_pulse(2, 1, model_evt(2));

        // Config 1: two full default frames, active-low sync.
        nfs  = 0;
        p1   = 0;
        p2   = 0;
        nlow = 0;
        for (int n = 1; n <= 2 * VT[1]; n++) begin
            drive_pulse(1, 1, model_evt(1));
            if (fs[1] === 1'b1) begin
                nfs++;
                if (nfs == 1) p1 = n;
                else p2 = n;
            end
            if (vs[1] === 1'b0) nlow++;
        end
        chk("frameStart count over two frames", 32'(nfs), 32'd2);
        chk("first frameStart event index", 32'(p1), 32'd1125);
        chk("frameStart spacing", 32'(p2 - p1), 32'd1125);
        chk("vSyncPulse low line count", 32'(nlow), 32'd10);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
